// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if -- operand and result handshake bundle for pe_seq_ctrl.
//   Operand channel : i_op_valid / o_op_ready carry one row of three a- and
//                     three b-elements (i_op_a, i_op_b).
//   Result channel  : o_res_valid / i_res_ready carry one dot-product result
//                     (o_res_data) tagged with its row index (o_res_idx).
//   slave  modport  : the sequencer side.
//   master modport  : the side that feeds operands and consumes results.
interface pe_seq_ctrl_if #(
   parameter int A = 8,
   parameter int B = 8,
   parameter int O = A + B + 2
);
   logic           i_op_valid;
   logic           o_op_ready;
   logic [3*A-1:0] i_op_a;
   logic [3*B-1:0] i_op_b;
   logic           o_res_valid;
   logic           i_res_ready;
   logic [O-1:0]   o_res_data;
   logic [7:0]     o_res_idx;

   modport slave (
      input  i_op_valid, i_op_a, i_op_b, i_res_ready,
      output o_op_ready, o_res_valid, o_res_data, o_res_idx
   );

   modport master (
      output i_op_valid, i_op_a, i_op_b, i_res_ready,
      input  o_op_ready, o_res_valid, o_res_data, o_res_idx
   );
endinterface

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl -- sequences rows of operands into a fixed-latency dot-product
// PE and buffers the PE results in a small show-ahead FIFO.
//   i_clk, i_resetn    : clock, asynchronous active-low reset
//   i_start            : job start request (honoured only when idle)
//   i_num_rows         : rows in the job, sampled on an accepted start
//   bus (slave)        : operand row in / result out handshakes
//   o_pe_mul_a/b       : registered operand drive to the PE (0 when idle)
//   i_pe_out           : PE dot-product result, valid PE_LAT edges after drive
//   o_busy             : job in progress (RUN or DRAIN)
//   o_done             : one-cycle pulse at job completion
// Every output is a flop; next values are computed in one combinational block.
module pe_seq_ctrl #(
   parameter int A      = 8,
   parameter int B      = 8,
   parameter int PE_LAT = 2,
   parameter int O      = A + B + 2
) (
   input  logic           i_clk,
   input  logic           i_resetn,
   input  logic           i_start,
   input  logic [7:0]     i_num_rows,
   pe_seq_ctrl_if.slave   bus,
   output logic [3*A-1:0] o_pe_mul_a,
   output logic [3*B-1:0] o_pe_mul_b,
   input  logic [O-1:0]   i_pe_out,
   output logic           o_busy,
   output logic           o_done
);

   localparam int D  = PE_LAT + 2;          // result FIFO depth
   localparam int PW = $clog2(D);           // FIFO pointer width
   localparam int CW = $clog2(D + 1);       // FIFO / inflight count width

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW:0]   CREDIT   = (CW + 1)'(D);

   // Number of rows still travelling through the PE tracking pipeline.
   function automatic logic [CW-1:0] count_ones(input logic [PE_LAT:0] v);
      logic [CW-1:0] n;
      n = CNT_ZERO;
      for (int i = 0; i <= PE_LAT; i++) begin
         n = n + {{(CW-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

   // Circular increment; the depth is generally not a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PW'(D - 1)) begin
         r = {PW{1'b0}};
      end else begin
         r = p + PW'(1);
      end
      return r;
   endfunction

   logic [1:0]     state_r,   state_nx_s;
   logic [7:0]     rows_r,    rows_nx_s;
   logic [7:0]     issue_r,   issue_nx_s;
   logic [7:0]     idx_r,     idx_nx_s;
   // track_r[0..PE_LAT-1] follow the PE pipeline; track_r[PE_LAT] marks the
   // cycle in which i_pe_out belongs to an issued row and is captured.
   logic [PE_LAT:0] track_r,  track_nx_s;
   logic [O-1:0]   mem_r [D];
   logic [PW-1:0]  wr_ptr_r,  wr_ptr_nx_s;
   logic [PW-1:0]  rd_ptr_r,  rd_ptr_nx_s;
   logic [CW-1:0]  cnt_r,     cnt_nx_s;
   logic [3*A-1:0] mul_a_r,   mul_a_nx_s;
   logic [3*B-1:0] mul_b_r,   mul_b_nx_s;
   logic           ready_r,   ready_nx_s;
   logic           valid_r,   valid_nx_s;
   logic [O-1:0]   data_r,    data_nx_s;
   logic           busy_r,    busy_nx_s;
   logic           done_r,    done_nx_s;

   logic           hs_s;
   logic           push_s;
   logic           pop_s;
   logic           start_ok_s;
   logic [CW-1:0]  inflight_s;
   logic [CW-1:0]  inflight_nx_s;

   assign hs_s          = bus.i_op_valid && ready_r;
   assign push_s        = track_r[PE_LAT];
   assign pop_s         = valid_r && bus.i_res_ready;
   assign start_ok_s    = (state_r == S_IDLE) && i_start && (i_num_rows != 8'd0);
   assign inflight_s    = count_ones(track_r);
   assign inflight_nx_s = count_ones(track_nx_s);

   assign bus.o_op_ready  = ready_r;
   assign bus.o_res_valid = valid_r;
   assign bus.o_res_data  = data_r;
   assign bus.o_res_idx   = idx_r;
   assign o_pe_mul_a      = mul_a_r;
   assign o_pe_mul_b      = mul_b_r;
   assign o_busy          = busy_r;
   assign o_done          = done_r;

   // Next-state computation for the FSM, counters, FIFO and all outputs.
   always_comb begin
      state_nx_s  = state_r;
      rows_nx_s   = rows_r;
      issue_nx_s  = issue_r;
      idx_nx_s    = idx_r;
      track_nx_s  = {track_r[PE_LAT-1:0], hs_s};
      wr_ptr_nx_s = wr_ptr_r;
      rd_ptr_nx_s = rd_ptr_r;
      cnt_nx_s    = cnt_r;
      data_nx_s   = data_r;
      mul_a_nx_s  = {(3*A){1'b0}};
      mul_b_nx_s  = {(3*B){1'b0}};

      case (state_r)
         S_IDLE: begin
            if (i_start) begin
               if (i_num_rows != 8'd0) begin
                  state_nx_s = S_RUN;
               end else begin
                  state_nx_s = S_DONE;
               end
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (hs_s && (issue_r == rows_r - 8'd1)) begin
               state_nx_s = S_DRAIN;
            end else begin
               state_nx_s = S_RUN;
            end
         end
         S_DRAIN: begin
            // Final pop: nothing else buffered and nothing left in the PE.
            if (pop_s && (cnt_r == CNT_ONE) && (inflight_s == CNT_ZERO)) begin
               state_nx_s = S_DONE;
            end else begin
               state_nx_s = S_DRAIN;
            end
         end
         S_DONE: begin
            state_nx_s = S_IDLE;
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase

      if (start_ok_s) begin
         rows_nx_s  = i_num_rows;
         issue_nx_s = 8'd0;
         idx_nx_s   = 8'd0;
      end else begin
         if (hs_s) begin
            issue_nx_s = issue_r + 8'd1;
         end else begin
            issue_nx_s = issue_r;
         end
         if (pop_s) begin
            idx_nx_s = idx_r + 8'd1;
         end else begin
            idx_nx_s = idx_r;
         end
      end

      if (hs_s) begin
         mul_a_nx_s = bus.i_op_a;
         mul_b_nx_s = bus.i_op_b;
      end else begin
         mul_a_nx_s = {(3*A){1'b0}};
         mul_b_nx_s = {(3*B){1'b0}};
      end

      if (push_s) begin
         wr_ptr_nx_s = ptr_inc(wr_ptr_r);
      end else begin
         wr_ptr_nx_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nx_s = ptr_inc(rd_ptr_r);
      end else begin
         rd_ptr_nx_s = rd_ptr_r;
      end

      case ({push_s, pop_s})
         2'b10:   cnt_nx_s = cnt_r + CNT_ONE;
         2'b01:   cnt_nx_s = cnt_r - CNT_ONE;
         default: cnt_nx_s = cnt_r;
      endcase

      // Registered show-ahead head: the next head is either the entry behind
      // the one being popped, or the incoming PE result when the FIFO would
      // otherwise be empty.
      if (pop_s) begin
         if (cnt_r > CNT_ONE) begin
            data_nx_s = mem_r[ptr_inc(rd_ptr_r)];
         end else if (push_s) begin
            data_nx_s = i_pe_out;
         end else begin
            data_nx_s = data_r;
         end
      end else if (push_s && (cnt_r == CNT_ZERO)) begin
         data_nx_s = i_pe_out;
      end else begin
         data_nx_s = data_r;
      end

      valid_nx_s = (cnt_nx_s != CNT_ZERO);
      busy_nx_s  = (state_nx_s == S_RUN) || (state_nx_s == S_DRAIN);
      done_nx_s  = (state_nx_s == S_DONE);
      // Credit check without counting a same-cycle pop, so the FIFO can
      // always absorb every row already sent into the PE.
      ready_nx_s = (state_nx_s == S_RUN) &&
                   (({1'b0, cnt_nx_s} + {1'b0, inflight_nx_s}) < CREDIT);
   end

   // Control, counter, tracking and output registers.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_r  <= S_IDLE;
         rows_r   <= 8'd0;
         issue_r  <= 8'd0;
         idx_r    <= 8'd0;
         track_r  <= {(PE_LAT+1){1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= CNT_ZERO;
         mul_a_r  <= {(3*A){1'b0}};
         mul_b_r  <= {(3*B){1'b0}};
         ready_r  <= 1'b0;
         valid_r  <= 1'b0;
         data_r   <= {O{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         rows_r   <= rows_nx_s;
         issue_r  <= issue_nx_s;
         idx_r    <= idx_nx_s;
         track_r  <= track_nx_s;
         wr_ptr_r <= wr_ptr_nx_s;
         rd_ptr_r <= rd_ptr_nx_s;
         cnt_r    <= cnt_nx_s;
         mul_a_r  <= mul_a_nx_s;
         mul_b_r  <= mul_b_nx_s;
         ready_r  <= ready_nx_s;
         valid_r  <= valid_nx_s;
         data_r   <= data_nx_s;
         busy_r   <= busy_nx_s;
         done_r   <= done_nx_s;
      end
   end

   // Result FIFO storage, written when a tracked row leaves the PE.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < D; i++) begin
            mem_r[i] <= {O{1'b0}};
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= i_pe_out;
         end
      end
   end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl -- scoreboard bench for pe_seq_ctrl. A behavioural PE feeds
// i_pe_out; a negedge monitor records accepted rows into an expected-result
// queue and checks every popped result, plus busy/done against a job model.
module tb_pe_seq_ctrl;
   localparam int A      = 8;
   localparam int B      = 8;
   localparam int PE_LAT = 2;
   localparam int O      = A + B + 2;

   typedef struct packed {
      logic [7:0]   idx;
      logic [O-1:0] data;
   } exp_t;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [7:0]     num_rows = 8'd0;
   logic [3*A-1:0] pe_mul_a;
   logic [3*B-1:0] pe_mul_b;
   logic [O-1:0]   pe_out;
   logic           busy;
   logic           done;
   logic [O-1:0]   pe_pipe [PE_LAT];

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   m_active = 1'b0;
   bit   m_done_exp = 1'b0;
   int   m_rows = 0, m_issued = 0, m_popped = 0, done_cnt = 0;
   exp_t exp_q[$];
   int   hs_log[$], pop_log[$], valid_log[$];
   logic [O-1:0] pop_data_log[$];
   logic [7:0]   pop_idx_log[$];
   bit   hold_v = 1'b0, prev_valid = 1'b0;
   logic [O-1:0] hold_d;
   logic [7:0]   hold_i;
   exp_t mon_e;
   logic [3*A-1:0] tab_a [4];
   logic [3*B-1:0] tab_b [4];

   pe_seq_ctrl_if #(.A(A), .B(B), .O(O)) bus ();

   pe_seq_ctrl #(.A(A), .B(B), .PE_LAT(PE_LAT), .O(O)) dut (
      .i_clk      (clk),
      .i_resetn   (rst_n),
      .i_start    (start),
      .i_num_rows (num_rows),
      .bus        (bus),
      .o_pe_mul_a (pe_mul_a),
      .o_pe_mul_b (pe_mul_b),
      .i_pe_out   (pe_out),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clk = ~clk;

   // Reference dot product of three element pairs.
   function automatic logic [O-1:0] dot3(input logic [3*A-1:0] a, input logic [3*B-1:0] b);
      int unsigned s;
      s = 0;
      for (int k = 0; k < 3; k++) begin
         s += 32'(a[k*A +: A]) * 32'(b[k*B +: B]);
      end
      return s[O-1:0];
   endfunction

   // Behavioural PE: result valid PE_LAT edges after its operands are driven.
   always @(posedge clk) begin
      pe_pipe[0] <= dot3(pe_mul_a, pe_mul_b);
      for (int k = 1; k < PE_LAT; k++) pe_pipe[k] <= pe_pipe[k-1];
   end
   assign pe_out = pe_pipe[PE_LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: everything seen here takes effect at the next posedge.
   always @(negedge clk) begin
      if (rst_n) begin
         bit pop;
         bit nd;
         chk("busy", 32'(busy), 32'(m_active));
         chk("done", 32'(done), 32'(m_done_exp));
         if (done) done_cnt++;
         chk("ready_legal", 32'(bus.o_op_ready && !(m_active && m_issued < m_rows)), 32'd0);
         if (hold_v) begin
            chk("hold_valid", 32'(bus.o_res_valid), 32'd1);
            chk("hold_data", 32'(bus.o_res_data), 32'(hold_d));
            chk("hold_idx", 32'(bus.o_res_idx), 32'(hold_i));
         end
         hold_v = bus.o_res_valid && !bus.i_res_ready;
         hold_d = bus.o_res_data;
         hold_i = bus.o_res_idx;
         if (bus.o_res_valid && !prev_valid) valid_log.push_back(cyc);
         prev_valid = bus.o_res_valid;

         if (bus.i_op_valid && bus.o_op_ready) begin
            exp_q.push_back('{idx: 8'(m_issued), data: dot3(bus.i_op_a, bus.i_op_b)});
            m_issued++;
            hs_log.push_back(cyc);
         end

         pop = bus.o_res_valid && bus.i_res_ready;
         if (pop) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'(bus.o_res_data), 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               chk("res_data", 32'(bus.o_res_data), 32'(mon_e.data));
               chk("res_idx", 32'(bus.o_res_idx), 32'(mon_e.idx));
            end
            m_popped++;
            pop_log.push_back(cyc);
            pop_data_log.push_back(bus.o_res_data);
            pop_idx_log.push_back(bus.o_res_idx);
         end

         nd = 1'b0;
         if (start && !m_active && !m_done_exp) begin
            if (num_rows == 8'd0) begin
               nd = 1'b1;
            end else begin
               m_active = 1'b1;
               m_rows   = int'(num_rows);
               m_issued = 0;
               m_popped = 0;
            end
         end else if (pop && m_active && m_popped == m_rows) begin
            m_active = 1'b0;
            nd = 1'b1;
         end
         m_done_exp = nd;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      hs_log.delete(); pop_log.delete(); valid_log.delete();
      pop_data_log.delete(); pop_idx_log.delete();
      done_cnt = 0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      m_active = 1'b0; m_done_exp = 1'b0;
      m_rows = 0; m_issued = 0; m_popped = 0;
      hold_v = 1'b0; prev_valid = 1'b0;
      clear_logs();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_op_ready"}, 32'(bus.o_op_ready), 32'd0);
      chk({tag, "_res_valid"}, 32'(bus.o_res_valid), 32'd0);
      chk({tag, "_res_data"}, 32'(bus.o_res_data), 32'd0);
      chk({tag, "_res_idx"}, 32'(bus.o_res_idx), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_mul_a"}, 32'(pe_mul_a), 32'd0);
      chk({tag, "_mul_b"}, 32'(pe_mul_b), 32'd0);
   endtask

   task automatic start_job(input int n);
      start = 1'b1;
      num_rows = 8'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while ((m_active || m_done_exp) && k < limit) begin
         tick();
         k++;
      end
      chk("job_timeout", 32'(m_active || m_done_exp), 32'd0);
      bus.i_op_valid = 1'b0;
      tick();
   endtask

   // Random job: random valid/ready, optional ignored restart with 9 rows.
   task automatic run_random_job(input int n, input int vprob, input int rprob, input bit restart);
      int k = 0;
      clear_logs();
      start_job(n);
      while ((m_active || m_done_exp) && k < 2000) begin
         bus.i_op_valid  = (m_issued < m_rows) && ($urandom_range(99) < vprob);
         bus.i_op_a      = 24'($urandom);
         bus.i_op_b      = 24'($urandom);
         bus.i_res_ready = ($urandom_range(99) < rprob);
         start    = restart && (k == 3);
         num_rows = (restart && k == 3) ? 8'd9 : num_rows;
         tick();
         k++;
      end
      start = 1'b0;
      chk("rand_timeout", 32'(m_active || m_done_exp), 32'd0);
      chk("rand_result_count", 32'(pop_log.size()), 32'(n));
      chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      bus.i_op_valid = 1'b0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.i_op_valid = 1'b0; bus.i_op_a = '0; bus.i_op_b = '0; bus.i_res_ready = 1'b0;
      tab_a[0] = {8'd3, 8'd2, 8'd1};       tab_b[0] = {8'd6, 8'd5, 8'd4};
      tab_a[1] = {8'd30, 8'd20, 8'd10};    tab_b[1] = {8'd1, 8'd1, 8'd1};
      tab_a[2] = {8'd0, 8'd7, 8'd0};       tab_b[2] = {8'd9, 8'd9, 8'd9};
      tab_a[3] = {8'd255, 8'd255, 8'd255}; tab_b[3] = {8'd255, 8'd255, 8'd255};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      clear_model();
      rst_n = 1'b1;
      tick();

      // Single row: latency, value 32, index 0, done after the pop.
      clear_logs();
      bus.i_res_ready = 1'b1;
      bus.i_op_a = tab_a[0];
      bus.i_op_b = tab_b[0];
      start_job(1);
      bus.i_op_valid = 1'b1;
      k = 0;
      while (m_issued < 1 && k < 50) begin tick(); k++; end
      bus.i_op_valid = 1'b0;
      wait_idle(50);
      chk("single_hs_count", 32'(hs_log.size()), 32'd1);
      chk("single_valid_seen", 32'(valid_log.size()), 32'd1);
      if (hs_log.size() == 1 && valid_log.size() == 1)
         chk("single_latency", 32'(valid_log[0]), 32'(hs_log[0] + 1 + PE_LAT + 1));
      chk("single_pops", 32'(pop_data_log.size()), 32'd1);
      if (pop_data_log.size() == 1) begin
         chk("single_data", 32'(pop_data_log[0]), 32'd32);
         chk("single_idx", 32'(pop_idx_log[0]), 32'd0);
      end
      chk("single_done_pulses", 32'(done_cnt), 32'd1);

      // Streaming four rows, ready held high, including the max-value row.
      clear_logs();
      start_job(4);
      k = 0;
      while ((m_active || m_done_exp) && k < 100) begin
         if (m_issued < 4) begin
            bus.i_op_valid = 1'b1;
            bus.i_op_a = tab_a[m_issued];
            bus.i_op_b = tab_b[m_issued];
         end else begin
            bus.i_op_valid = 1'b0;
         end
         tick();
         k++;
      end
      wait_idle(10);
      chk("stream_hs_count", 32'(hs_log.size()), 32'd4);
      chk("stream_pop_count", 32'(pop_log.size()), 32'd4);
      if (hs_log.size() == 4 && pop_log.size() == 4) begin
         chk("stream_hs_span", 32'(hs_log[3] - hs_log[0]), 32'd3);
         chk("stream_pop_span", 32'(pop_log[3] - pop_log[0]), 32'd3);
         chk("stream_row1", 32'(pop_data_log[1]), 32'd60);
         chk("stream_row2", 32'(pop_data_log[2]), 32'd63);
         chk("stream_max", 32'(pop_data_log[3]), 32'd195075);
         chk("stream_last_idx", 32'(pop_idx_log[3]), 32'd3);
      end

      // Backpressure: eight rows, ready low until the credit runs out.
      clear_logs();
      bus.i_res_ready = 1'b0;
      start_job(8);
      for (int i = 0; i < 12; i++) begin
         bus.i_op_valid = (m_issued < 8);
         bus.i_op_a = 24'($urandom);
         bus.i_op_b = 24'($urandom);
         tick();
      end
      chk("bp_issued", 32'(m_issued), 32'd4);
      chk("bp_ready_low", 32'(bus.o_op_ready), 32'd0);
      bus.i_res_ready = 1'b1;
      k = 0;
      while ((m_active || m_done_exp) && k < 200) begin
         bus.i_op_valid = (m_issued < 8);
         bus.i_op_a = 24'($urandom);
         bus.i_op_b = 24'($urandom);
         tick();
         k++;
      end
      wait_idle(10);
      chk("bp_results", 32'(pop_log.size()), 32'd8);
      chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Zero rows: done pulse only, no busy, no result.
      clear_logs();
      start_job(0);
      repeat (4) tick();
      chk("zero_done_pulses", 32'(done_cnt), 32'd1);
      chk("zero_no_result", 32'(valid_log.size()), 32'd0);

      // Mid-job reset after two of five rows, then a clean one-row job.
      clear_logs();
      bus.i_res_ready = 1'b0;
      start_job(5);
      k = 0;
      while (m_issued < 2 && k < 50) begin
         bus.i_op_valid = 1'b1;
         bus.i_op_a = 24'($urandom);
         bus.i_op_b = 24'($urandom);
         tick();
         k++;
      end
      bus.i_op_valid = 1'b0;
      chk("mid_issued", 32'(m_issued), 32'd2);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      clear_model();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      bus.i_res_ready = 1'b1;
      bus.i_op_a = {8'd9, 8'd8, 8'd7};
      bus.i_op_b = {8'd3, 8'd2, 8'd1};
      start_job(1);
      bus.i_op_valid = 1'b1;
      k = 0;
      while (m_issued < 1 && k < 50) begin tick(); k++; end
      bus.i_op_valid = 1'b0;
      wait_idle(50);
      chk("postrst_pops", 32'(pop_data_log.size()), 32'd1);
      if (pop_data_log.size() == 1) begin
         chk("postrst_data", 32'(pop_data_log[0]), 32'd50);
         chk("postrst_idx", 32'(pop_idx_log[0]), 32'd0);
      end

      // Start pulsed while busy must be ignored; then random jobs.
      run_random_job(6, 80, 70, 1'b1);
      for (int j = 0; j < 8; j++) begin
         run_random_job($urandom_range(12), $urandom_range(30, 100), $urandom_range(20, 100), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
